// File: rtl/bids22_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bids22_round_ctrl
//  Description : Host-side round sequencer for the three-bidder auction unit.
//                Snapshots a round configuration on start, programs and locks
//                the auction unit, holds C_start for the round length, waits
//                for roundOver and unlocks the unit with the same key.
//  Options     : BIDS_CTRL_TIMEOUT_EN - enables a roundOver watchdog in CLS
//                (fault code 3 after TIMEOUT cycles without roundOver).
//  Revision    : 1.0 - initial release
// ============================================================================
module bids22_round_ctrl #(
    parameter int ROUND_W = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic [31:0]        cfg_x,
    input  logic [31:0]        cfg_y,
    input  logic [31:0]        cfg_z,
    input  logic [2:0]         cfg_mask,
    input  logic [31:0]        cfg_timer,
    input  logic [31:0]        cfg_cost,
    input  logic [31:0]        cfg_key,
    input  logic [ROUND_W-1:0] cfg_len,
    input  logic               ready,
    input  logic               roundOver,
    input  logic [2:0]         err,
    output logic [3:0]         C_op,
    output logic [31:0]        C_data,
    output logic               C_start,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [2:0]         fault_code
);

`ifdef BIDS_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_NOOP    = 4'd0;
    localparam logic [3:0] OP_UNLOCK  = 4'd1;
    localparam logic [3:0] OP_LOCK    = 4'd2;
    localparam logic [3:0] OP_LOADX   = 4'd3;
    localparam logic [3:0] OP_LOADY   = 4'd4;
    localparam logic [3:0] OP_LOADZ   = 4'd5;
    localparam logic [3:0] OP_SETMASK = 4'd6;
    localparam logic [3:0] OP_SETTMR  = 4'd7;
    localparam logic [3:0] OP_BIDCHG  = 4'd8;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_CONFIG  = 3'd1;
    localparam logic [2:0] FC_ROUND   = 3'd2;
    localparam logic [2:0] FC_TIMEOUT = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LDX   = 4'd1,
        S_LDY   = 4'd2,
        S_LDZ   = 4'd3,
        S_MSK   = 4'd4,
        S_TMR   = 4'd5,
        S_CST   = 4'd6,
        S_LCK   = 4'd7,
        S_RND   = 4'd8,
        S_CLS   = 4'd9,
        S_ULK   = 4'd10,
        S_DN    = 4'd11,
        S_FAULT = 4'd12
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               fault_set;
    logic [2:0]         fault_val;

    logic [31:0]        snap_x;
    logic [31:0]        snap_y;
    logic [31:0]        snap_z;
    logic [2:0]         snap_mask;
    logic [31:0]        snap_timer;
    logic [31:0]        snap_cost;
    logic [31:0]        snap_key;
    logic [ROUND_W-1:0] round_cnt;
    logic [31:0]        to_cnt;

    // Next-state selection; an error check always wins over advancing.
    always_comb begin
        state_nxt = state;
        fault_set = 1'b0;
        fault_val = FC_NONE;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LDX;
            S_LDX:   if (ready) state_nxt = S_LDY;
            S_LDY, S_LDZ, S_MSK, S_TMR, S_CST, S_LCK: begin
                if (err != 3'd0) begin
                    state_nxt = S_FAULT;
                    fault_set = 1'b1;
                    fault_val = FC_CONFIG;
                end else if (ready) begin
                    case (state)
                        S_LDY:   state_nxt = S_LDZ;
                        S_LDZ:   state_nxt = S_MSK;
                        S_MSK:   state_nxt = S_TMR;
                        S_TMR:   state_nxt = S_CST;
                        S_CST:   state_nxt = S_LCK;
                        default: state_nxt = S_RND;
                    endcase
                end
            end
            S_RND: begin
                if (err != 3'd0) begin
                    state_nxt = S_FAULT;
                    fault_set = 1'b1;
                    fault_val = FC_ROUND;
                end else if (round_cnt == ROUND_W'(1)) begin
                    state_nxt = S_CLS;
                end
            end
            // No error check here: roundOver is the only way forward.
            S_CLS: begin
                if (roundOver) begin
                    state_nxt = S_ULK;
                end else if (TIMEOUT_EN && (to_cnt <= 32'd1)) begin
                    state_nxt = S_FAULT;
                    fault_set = 1'b1;
                    fault_val = FC_TIMEOUT;
                end
            end
            S_ULK:   if (ready) state_nxt = S_DN;
            S_DN:    state_nxt = S_IDLE;
            S_FAULT: if (clear) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Configuration snapshot, taken once per round so the host may change cfg_* freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_x     <= 32'd0;
            snap_y     <= 32'd0;
            snap_z     <= 32'd0;
            snap_mask  <= 3'd0;
            snap_timer <= 32'd0;
            snap_cost  <= 32'd0;
            snap_key   <= 32'd0;
        end else if (state == S_IDLE && start) begin
            snap_x     <= cfg_x;
            snap_y     <= cfg_y;
            snap_z     <= cfg_z;
            snap_mask  <= cfg_mask;
            snap_timer <= cfg_timer;
            snap_cost  <= cfg_cost;
            snap_key   <= cfg_key;
        end
    end

    // Round-length counter; a zero length is promoted to one so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            round_cnt <= (cfg_len == '0) ? ROUND_W'(1) : cfg_len;
        end else if (state == S_RND && round_cnt != '0) begin
            round_cnt <= round_cnt - ROUND_W'(1);
        end
    end

    // roundOver watchdog: armed on entry to CLS, counts down while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= 32'd0;
        end else if (state != S_CLS) begin
            to_cnt <= 32'(TIMEOUT);
        end else if (to_cnt != 32'd0) begin
            to_cnt <= to_cnt - 32'd1;
        end
    end

    // Fault code latches on the transition into FAULT and clears on leaving it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_code <= FC_NONE;
        end else if (fault_set) begin
            fault_code <= fault_val;
        end else if (state == S_FAULT && clear) begin
            fault_code <= FC_NONE;
        end
    end

    // Command port and status decoded purely from registered state.
    always_comb begin
        C_op    = OP_NOOP;
        C_data  = 32'd0;
        C_start = 1'b0;
        busy    = (state != S_IDLE) && (state != S_FAULT);
        done    = (state == S_DN);
        fault   = (state == S_FAULT);
        case (state)
            S_LDX: begin C_op = OP_LOADX;   C_data = snap_x;              end
            S_LDY: begin C_op = OP_LOADY;   C_data = snap_y;              end
            S_LDZ: begin C_op = OP_LOADZ;   C_data = snap_z;              end
            S_MSK: begin C_op = OP_SETMASK; C_data = {29'd0, snap_mask};  end
            S_TMR: begin C_op = OP_SETTMR;  C_data = snap_timer;          end
            S_CST: begin C_op = OP_BIDCHG;  C_data = snap_cost;           end
            S_LCK: begin C_op = OP_LOCK;    C_data = snap_key;            end
            S_RND: C_start = 1'b1;
            S_ULK: begin C_op = OP_UNLOCK;  C_data = snap_key;            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bids22_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bids22_round_ctrl
//  Description : Scoreboard bench for bids22_round_ctrl. Each scenario pushes
//                one expected output record per cycle; a negedge monitor pops
//                and compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bids22_round_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] cfg_x = '0, cfg_y = '0, cfg_z = '0;
    logic [2:0]  cfg_mask = '0;
    logic [31:0] cfg_timer = '0, cfg_cost = '0, cfg_key = '0;
    logic [15:0] cfg_len = '0;
    logic        ready = 1'b1;
    logic        roundOver = 1'b0;
    logic [2:0]  err = '0;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start, busy, done, fault;
    logic [2:0]  fault_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] data;
        logic        st, bsy, dn, flt;
        logic [2:0]  fc;
    } exp_t;

    exp_t exp_q[$];

    bids22_round_ctrl #(.ROUND_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z), .cfg_mask(cfg_mask),
        .cfg_timer(cfg_timer), .cfg_cost(cfg_cost), .cfg_key(cfg_key),
        .cfg_len(cfg_len), .ready(ready), .roundOver(roundOver), .err(err),
        .C_op(C_op), .C_data(C_data), .C_start(C_start), .busy(busy),
        .done(done), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] op, input logic [31:0] d,
                        input logic st, input logic bsy, input logic dn,
                        input logic flt, input logic [2:0] fc);
        exp_t e;
        e.tag = tag; e.op = op; e.data = d;
        e.st = st; e.bsy = bsy; e.dn = dn; e.flt = flt; e.fc = fc;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        push(tag, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // Commands LDX..LCK; MSK repeats for every stalled cycle plus one.
    task automatic push_cmds(input logic [31:0] x, y, z, input logic [2:0] m,
                             input logic [31:0] t, c, k, input int stall, input int upto);
        logic [3:0]  ops [7];
        logic [31:0] dat [7];
        ops = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        dat = '{x, y, z, {29'd0, m}, t, c, k};
        for (int i = 0; i < upto; i++)
            for (int r = 0; r < ((i == 3) ? stall + 1 : 1); r++)
                push($sformatf("cmd%0d", i), ops[i], dat[i], 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] x, y, z, input logic [2:0] m,
                           input logic [31:0] t, c, k, input logic [15:0] len);
        cfg_x = x; cfg_y = y; cfg_z = z; cfg_mask = m;
        cfg_timer = t; cfg_cost = c; cfg_key = k; cfg_len = len;
    endtask

    // Complete round; cfg_* is scrambled after start to prove it was snapshotted.
    task automatic run_round(input logic [31:0] x, y, z, input logic [2:0] m,
                             input logic [31:0] t, c, k, input logic [15:0] len,
                             input int stall, input int ro_delay);
        int len_eff;
        int rc;
        len_eff = (len == 16'd0) ? 1 : int'(len);
        rc = 8 + stall + len_eff + ro_delay;
        push_idle("idle0");
        push_cmds(x, y, z, m, t, c, k, stall, 7);
        for (int i = 0; i < len_eff; i++) push("rnd", 4'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i <= ro_delay; i++) push("cls", 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        push("ulk", 4'd1, k, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        push("dn", 4'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        push_idle("idle_end");
        set_cfg(x, y, z, m, t, c, k, len);
        for (int cy = 0; cy <= rc + 3; cy++) begin
            start     = (cy == 0);
            ready     = !(cy >= 4 && cy < 4 + stall);
            roundOver = (cy == rc);
            if (cy == 1) set_cfg(~x, ~y, ~z, ~m, ~t, ~c, ~k, len + 16'd5);
            next_cyc;
        end
        start = 1'b0; ready = 1'b1; roundOver = 1'b0;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Negedge monitor: one expected record per cycle while the queue is non-empty.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".op"},    32'(C_op),       32'(e.op));
            chk({e.tag, ".data"},  C_data,          e.data);
            chk({e.tag, ".start"}, 32'(C_start),    32'(e.st));
            chk({e.tag, ".busy"},  32'(busy),       32'(e.bsy));
            chk({e.tag, ".done"},  32'(done),       32'(e.dn));
            chk({e.tag, ".fault"}, 32'(fault),      32'(e.flt));
            chk({e.tag, ".fcode"}, 32'(fault_code), 32'(e.fc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        next_cyc; next_cyc;
        chk("rst.op", 32'(C_op), 32'd0);
        chk("rst.data", C_data, 32'd0);
        chk("rst.start", 32'(C_start), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.fcode", 32'(fault_code), 32'd0);
        reset = 1'b0;
        next_cyc;

        // Nominal round
        run_round(32'd100, 32'd200, 32'd300, 3'b111, 32'd15, 32'd1, 32'h0F0F0F0F, 16'd4, 0, 1);

        // Backpressure in MSK
        run_round(32'hA5A5_0001, 32'h5A5A_0002, 32'h1234_5678, 3'b101, 32'd99, 32'd7,
                  32'hDEAD_BEEF, 16'd3, 3, 2);

        // Config error in TMR, then clear and a clean round
        push_idle("e.idle0");
        push_cmds(32'd11, 32'd22, 32'd33, 3'b010, 32'd44, 32'd55, 32'h66, 0, 5);
        push("e.fault", 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        push("e.fault", 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        push_idle("e.idle_end");
        set_cfg(32'd11, 32'd22, 32'd33, 3'b010, 32'd44, 32'd55, 32'h66, 16'd2);
        for (int cy = 0; cy <= 8; cy++) begin
            start = (cy == 0);
            err   = (cy == 5) ? 3'b100 : 3'b000;
            clear = (cy == 7);
            next_cyc;
        end
        start = 1'b0; err = '0; clear = 1'b0;
        chk("e.drain", 32'(exp_q.size()), 32'd0);
        run_round(32'd1, 32'd2, 32'd3, 3'b001, 32'd4, 32'd5, 32'h0BAD_F00D, 16'd2, 0, 0);

        // Zero length gives exactly one C_start cycle
        run_round(32'd7, 32'd8, 32'd9, 3'b110, 32'd10, 32'd11, 32'h1234_0000, 16'd0, 0, 1);

        // Reset in the second RND cycle
        push_idle("r.idle0");
        push_cmds(32'd5, 32'd6, 32'd7, 3'b011, 32'd8, 32'd9, 32'hCAFE, 0, 7);
        push("r.rnd", 4'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        push("r.rnd", 4'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        push_idle("r.after_reset");
        set_cfg(32'd5, 32'd6, 32'd7, 3'b011, 32'd8, 32'd9, 32'hCAFE, 16'd4);
        for (int cy = 0; cy <= 10; cy++) begin
            start = (cy == 0);
            reset = (cy == 9);
            next_cyc;
        end
        start = 1'b0; reset = 1'b0;
        chk("r.drain", 32'(exp_q.size()), 32'd0);

        // Missing roundOver
        push_idle("t.idle0");
        push_cmds(32'd1, 32'd1, 32'd1, 3'b111, 32'd1, 32'd1, 32'h77, 0, 7);
        push("t.rnd", 4'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        set_cfg(32'd1, 32'd1, 32'd1, 3'b111, 32'd1, 32'd1, 32'h77, 16'd1);
`ifdef BIDS_CTRL_TIMEOUT_EN
        for (int i = 0; i < 16; i++) push("t.cls", 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        push("t.fault", 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        push("t.fault", 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        push_idle("t.idle_end");
        for (int cy = 0; cy <= 27; cy++) begin
            start = (cy == 0);
            clear = (cy == 26);
            next_cyc;
        end
        clear = 1'b0;
`else
        for (int i = 0; i < 100; i++) push("t.cls", 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        push_idle("t.after_reset");
        for (int cy = 0; cy <= 109; cy++) begin
            start = (cy == 0);
            reset = (cy == 108);
            next_cyc;
        end
        reset = 1'b0;
`endif
        start = 1'b0;
        chk("t.drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
